// File: rtl/one_hot_decoder_if.sv
// Stream interface of the one-hot to binary decoder: input word handshake,
// decoded output handshake and error-count side signals.
interface one_hot_decoder_if #(
  parameter int unsigned binary_word  = 4,
  parameter int unsigned one_hot_word = 16,
  parameter int unsigned err_cnt_word = 8
);
  logic [one_hot_word-1:0] one_hot_i;
  logic                    valid_i;
  logic                    ready_o;
  logic [binary_word-1:0]  bin_o;
  logic                    err_o;
  logic                    valid_o;
  logic                    ready_i;
  logic                    err_clr_i;
  logic [err_cnt_word-1:0] err_count_o;

  // master drives words in and consumes results; slave is the decoder
  modport master (
    output one_hot_i, valid_i, ready_i, err_clr_i,
    input  ready_o, bin_o, err_o, valid_o, err_count_o
  );

  modport slave (
    input  one_hot_i, valid_i, ready_i, err_clr_i,
    output ready_o, bin_o, err_o, valid_o, err_count_o
  );
endinterface

// File: rtl/one_hot_decoder.sv
// Registered one-hot to binary decoder with a two-entry skid buffer.
// Define ONE_HOT_DECODER_ERR_CNT_EN to build the saturating malformed-word counter.
module one_hot_decoder #(
  parameter int unsigned binary_word  = 4,
  parameter int unsigned one_hot_word = 16,
  parameter int unsigned err_cnt_word = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  one_hot_decoder_if.slave   bus
);

  typedef struct packed {
    logic [binary_word-1:0] bin;
    logic                   err;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   ready_q, ready_d;
  logic   valid_q, valid_d;

  entry_t dec;
  logic   accept;
  logic   pop;

  // Lowest set bit wins; zero or more than one set bit flags the word.
  always_comb begin
    dec.bin = '0;
    dec.err = (bus.one_hot_i == '0) ||
              ((bus.one_hot_i & (bus.one_hot_i - one_hot_word'(1))) != '0);
    for (int i = one_hot_word - 1; i >= 0; i--) begin
      if (bus.one_hot_i[i]) dec.bin = binary_word'(i);
    end
  end

  assign accept = bus.valid_i && ready_q;
  assign pop    = valid_q && bus.ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  // Occupancy FSM; ready/valid are precomputed from the next state so both stay registered.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = dec;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && !pop) begin
          skid_d  = dec;
          state_d = FULL;
        end else if (accept && pop) begin
          main_d  = dec;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    ready_d = (state_d != FULL);
    valid_d = (state_d != EMPTY);
  end

  assign bus.ready_o = ready_q;
  assign bus.valid_o = valid_q;
  assign bus.bin_o   = main_q.bin;
  assign bus.err_o   = main_q.err;

`ifdef ONE_HOT_DECODER_ERR_CNT_EN
  logic [err_cnt_word-1:0] err_cnt_q;

  // Clear beats increment; the count sticks at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if (bus.err_clr_i) begin
      err_cnt_q <= '0;
    end else if (accept && dec.err && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + err_cnt_word'(1);
    end
  end

  assign bus.err_count_o = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr  = bus.err_clr_i;
  assign bus.err_count_o = '0;
`endif

endmodule

// File: tb/tb_one_hot_decoder.sv
// Directed self-checking bench for one_hot_decoder (2-bit error counter so
// saturation is reachable); count expectations follow ONE_HOT_DECODER_ERR_CNT_EN.
module tb_one_hot_decoder;

  localparam int unsigned binary_word  = 4;
  localparam int unsigned one_hot_word = 16;
  localparam int unsigned err_cnt_word = 2;

`ifdef ONE_HOT_DECODER_ERR_CNT_EN
  localparam bit cnt_en = 1'b1;
`else
  localparam bit cnt_en = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  one_hot_decoder_if #(
    .binary_word (binary_word),
    .one_hot_word(one_hot_word),
    .err_cnt_word(err_cnt_word)
  ) bus ();

  one_hot_decoder #(
    .binary_word (binary_word),
    .one_hot_word(one_hot_word),
    .err_cnt_word(err_cnt_word)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] w);
    bus.valid_i   = v;
    bus.one_hot_i = w;
  endtask

  function automatic logic [31:0] cnt(input int n);
    return cnt_en ? 32'(n) : 32'd0;
  endfunction

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.ready_i   = 1'b1;
    bus.err_clr_i = 1'b0;
    drive(1'b1, 16'h0001);

    // reset held with valid high
    repeat (3) step();
    check("rst_ready", 32'(bus.ready_o), 32'd0);
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_bin", 32'(bus.bin_o), 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    check("rst_cnt", 32'(bus.err_count_o), 32'd0);
    rst_n = 1'b1;
    step();
    check("rel_ready", 32'(bus.ready_o), 32'd1);
    check("rel_valid", 32'(bus.valid_o), 32'd0);

    // streaming, 1-cycle latency
    drive(1'b1, 16'h0001); step();
    check("s0_valid", 32'(bus.valid_o), 32'd1);
    check("s0_bin", 32'(bus.bin_o), 32'd0);
    check("s0_err", 32'(bus.err_o), 32'd0);
    drive(1'b1, 16'h0020); step();
    check("s1_bin", 32'(bus.bin_o), 32'd5);
    check("s1_err", 32'(bus.err_o), 32'd0);
    drive(1'b1, 16'h8000); step();
    check("s2_bin", 32'(bus.bin_o), 32'd15);
    check("s2_err", 32'(bus.err_o), 32'd0);
    drive(1'b0, 16'h0000); step();
    check("s_drain", 32'(bus.valid_o), 32'd0);

    // malformed words
    drive(1'b1, 16'h0000); step();
    check("m0_bin", 32'(bus.bin_o), 32'd0);
    check("m0_err", 32'(bus.err_o), 32'd1);
    check("m0_cnt", 32'(bus.err_count_o), cnt(1));
    drive(1'b1, 16'h0014); step();
    check("m1_bin", 32'(bus.bin_o), 32'd2);
    check("m1_err", 32'(bus.err_o), 32'd1);
    check("m1_cnt", 32'(bus.err_count_o), cnt(2));
    drive(1'b0, 16'h0000); step();

    // backpressure through the skid register
    bus.ready_i = 1'b0;
    drive(1'b1, 16'h0002); step();
    check("bp0_bin", 32'(bus.bin_o), 32'd1);
    check("bp0_ready", 32'(bus.ready_o), 32'd1);
    drive(1'b1, 16'h0004); step();
    check("bp1_ready", 32'(bus.ready_o), 32'd0);
    check("bp1_bin", 32'(bus.bin_o), 32'd1);
    drive(1'b1, 16'h0008); step();
    check("bp2_ready", 32'(bus.ready_o), 32'd0);
    check("bp2_hold", 32'(bus.bin_o), 32'd1);
    check("bp2_valid", 32'(bus.valid_o), 32'd1);
    bus.ready_i = 1'b1; step();
    check("bp3_bin", 32'(bus.bin_o), 32'd2);
    check("bp3_ready", 32'(bus.ready_o), 32'd1);
    step();
    check("bp4_bin", 32'(bus.bin_o), 32'd3);
    check("bp4_valid", 32'(bus.valid_o), 32'd1);
    drive(1'b0, 16'h0000); step();
    check("bp5_valid", 32'(bus.valid_o), 32'd0);

    // saturation of the 2-bit counter, then clear beating an increment
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h0000); step();
    end
    check("sat_cnt", 32'(bus.err_count_o), cnt(3));
    bus.err_clr_i = 1'b1;
    drive(1'b1, 16'h0300); step();
    bus.err_clr_i = 1'b0;
    check("clr_cnt", 32'(bus.err_count_o), 32'd0);
    check("clr_bin", 32'(bus.bin_o), 32'd8);
    check("clr_err", 32'(bus.err_o), 32'd1);
    drive(1'b1, 16'h0400); step();
    check("post_clr_cnt", 32'(bus.err_count_o), 32'd0);
    check("post_clr_bin", 32'(bus.bin_o), 32'd10);
    drive(1'b1, 16'hffff); step();
    check("post_clr_inc", 32'(bus.err_count_o), cnt(1));

    // asynchronous reset with a word held in main
    bus.ready_i = 1'b0;
    drive(1'b1, 16'h0010); step();
    check("pre_ar_valid", 32'(bus.valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(bus.valid_o), 32'd0);
    check("ar_ready", 32'(bus.ready_o), 32'd0);
    check("ar_bin", 32'(bus.bin_o), 32'd0);
    check("ar_cnt", 32'(bus.err_count_o), 32'd0);
    drive(1'b0, 16'h0000);
    step();
    rst_n = 1'b1;
    bus.ready_i = 1'b1;
    step();
    step();
    check("ar_after_valid", 32'(bus.valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/one_hot_decoder.md
# one_hot_decoder

Registered one-hot to binary decoder, the receiving end of the one-hot select buses produced by the binary-to-one-hot converter. It accepts one one-hot word per valid/ready transfer and returns its binary index one cycle later. Malformed words (all-zero or multi-hot) are flagged per word and counted. A two-entry skid buffer gives a registered `ready_o` so the block can sit between pipeline stages without a combinational ready path.

## Interface
- `binary_word`, 4: width of `bin_o`; must satisfy `one_hot_word <= 2**binary_word`.
- `one_hot_word`, 16: width of `one_hot_i`.
- `err_cnt_word`, 8: width of `err_count_o`.

- `clk_i`  input  1  clock; all state updates on the rising edge.
- `rst_ni`  input  1  reset; asynchronous, active-low.
- `one_hot_i`  input  `one_hot_word`  input word.
- `valid_i`  input  1  `one_hot_i` valid.
- `ready_o`  output  1  block can accept; registered.
- `bin_o`  output  `binary_word`  decoded index.
- `err_o`  output  1  word at `bin_o` was not exactly one-hot.
- `valid_o`  output  1  `bin_o`/`err_o` valid.
- `ready_i`  input  1  downstream accepts.
- `err_clr_i`  input  1  synchronous clear of `err_count_o`.
- `err_count_o`  output  `err_cnt_word`  saturating count of malformed words accepted.

## Operation
- Input transfer when `valid_i && ready_o` at a rising edge; output transfer when `valid_o && ready_i`.
- Decode: exactly one bit set at position k gives `bin_o = k`, `err_o = 0`.
- Multi-hot: `bin_o` = index of the lowest set bit, `err_o = 1`.
- All-zero: `bin_o = 0`, `err_o = 1`.
- Storage: output register (main) plus one skid register, each holding {bin, err}.
- States by occupancy:
  - EMPTY: main empty, skid empty.
  - ONE: main full, skid empty.
  - FULL: main full, skid full.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + no pop -> FULL; the new word goes to skid.
  - ONE + accept + pop -> ONE; the new word replaces main.
  - ONE + pop only -> EMPTY.
  - FULL + pop -> ONE; skid moves to main. No accept is possible in FULL.
- `ready_o` = 1 in EMPTY and ONE; 0 in FULL and while reset is asserted.
- Ordering is strict FIFO; no word is dropped or duplicated.
- `bin_o`/`err_o` hold stable while `valid_o && !ready_i`.
- Error counter:
  - Increments by 1 at each input transfer whose word is malformed.
  - Saturates at `2**err_cnt_word - 1`.
  - `err_clr_i` sets it to 0; clear wins over a simultaneous increment.

## Timing
- Reset (`rst_ni` low, asynchronous): `valid_o`=0, `bin_o`=0, `err_o`=0, `err_count_o`=0, `ready_o`=0, both entries emptied.
- `ready_o` rises at the first rising edge after `rst_ni` deasserts.
- Latency: a word accepted at edge N appears on `valid_o`/`bin_o` after edge N, i.e. 1 cycle, when main is empty or is being popped at N.
- Throughput: 1 word/cycle while `ready_i` stays high.
- `ready_o` drops the cycle after the skid fills and rises the cycle after the skid drains.
- Reset asserted mid-transfer discards both entries and the count; there is no partial output.
- `err_count_o` updates at the accepting edge, independent of output backpressure.

## Configuration
- `ONE_HOT_DECODER_ERR_CNT_EN` defined: the error counter and `err_clr_i` logic are built as described.
- Not defined: no counter flops are built, `err_count_o` is tied to 0, and `err_clr_i` is ignored.
- `err_o` is always present in both builds.

## Test plan
- Reset: hold `rst_ni`=0 with `valid_i`=1 -> `ready_o`=0 and `valid_o`=0; one edge after release -> `ready_o`=1.
- Streaming: `ready_i`=1, send 16'h0001, 16'h0020, 16'h8000 on back-to-back cycles -> `bin_o` 0, 5, 15 on consecutive cycles, `err_o`=0, 1-cycle latency.
- Malformed words: send 16'h0000 then 16'h0014 -> `bin_o`=0 with `err_o`=1, then `bin_o`=2 with `err_o`=1; `err_count_o`=2.
- Backpressure: `ready_i`=0, send 16'h0002, 16'h0004, 16'h0008 -> first two accepted, `ready_o`=0, third held upstream. Raise `ready_i` -> outputs 1, 2, 3 in order with none lost.
- Counter saturation and clear: `err_cnt_word`=2, send 5 all-zero words -> `err_count_o`=3. Assert `err_clr_i` together with a malformed accept -> `err_count_o`=0.
- Macro off: build without `ONE_HOT_DECODER_ERR_CNT_EN`, send malformed words -> `err_o`=1 and `err_count_o` stays 0.
